// File: rtl/encoder_8to3_serial_pkg.sv
// Shared widths, types and FSM state encoding for the serialising 8-to-3 encoder.
package encoder_pkg;

  localparam int REQ_W = 8;
  localparam int IDX_W = 3;

  typedef logic [REQ_W-1:0] req_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    ENC_IDLE,
    ENC_EMIT
  } enc_state_t;

endpackage

// File: rtl/encoder_8to3_serial_if.sv
// Request-in / index-out handshake bundle; the encoder is the slave side,
// the surrounding logic (producer plus consumer) is the master side.
interface encoder_8to3_serial_if;
  import encoder_pkg::*;

  logic in_valid;
  logic in_ready;
  req_t in_req;
  logic out_valid;
  logic out_ready;
  idx_t out_idx;
  logic out_last;
  logic out_zero;

  modport slave (
    input  in_valid, in_req, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_zero
  );

  modport master (
    output in_valid, in_req, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_zero
  );

endinterface

// File: rtl/encoder_8to3_serial_lsb_idx_enc.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit plus
// "exactly one bit set" and "any bit set" flags. Index is 0 for a zero vector.
module lsb_idx_enc
  import encoder_pkg::*;
(
  input  req_t vec_i,
  output idx_t idx_o,
  output logic one_o,
  output logic any_o
);

  // NOTE: idx_o gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    idx_o = '0;
    // Scan downwards so the lowest set bit is the last (winning) assignment.
    for (int i = REQ_W - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = idx_t'(i);
    end
  end

  assign any_o = |vec_i;
  assign one_o = any_o && ((vec_i & (vec_i - req_t'(1))) == '0);

endmodule

// File: rtl/encoder_8to3_serial.sv
// Serialising 8-to-3 encoder: accepts a request vector, then emits the index of
// every set bit, lowest first, one per beat. Optional macro ENCODER_ZERO_FLAG_EN
// makes an all-zero vector produce a single out_zero beat instead of nothing.
module encoder_8to3_serial
  import encoder_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  encoder_8to3_serial_if.slave bus
);

  enc_state_t state_q, state_d;
  req_t       pending_q, pending_d;

  idx_t lsb_idx;
  logic lsb_one;
  logic lsb_any;
  logic emit;
  logic zero_beat;
  logic last_beat;
  logic accept_in;
  logic enter_emit;

  lsb_idx_enc u_lsb_idx_enc (
    .vec_i (pending_q),
    .idx_o (lsb_idx),
    .one_o (lsb_one),
    .any_o (lsb_any)
  );

  assign emit = (state_q == ENC_EMIT);

`ifdef ENCODER_ZERO_FLAG_EN
  // Pending is only empty in EMIT when an all-zero vector was accepted.
  assign zero_beat  = emit && !lsb_any;
  assign enter_emit = 1'b1;
`else
  assign zero_beat  = 1'b0;
  assign enter_emit = |bus.in_req;
`endif

  assign last_beat = emit && (lsb_one || zero_beat);
  assign accept_in = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !emit && !rst;
  assign bus.out_valid = emit;
  assign bus.out_idx   = lsb_idx;
  assign bus.out_last  = last_beat;
  assign bus.out_zero  = zero_beat;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      ENC_IDLE: begin
        if (accept_in) begin
          pending_d = bus.in_req;
          if (enter_emit) state_d = ENC_EMIT;
        end
      end
      ENC_EMIT: begin
        if (bus.out_ready) begin
          pending_d = pending_q & ~(req_t'(1) << lsb_idx);
          if (last_beat) state_d = ENC_IDLE;
        end
      end
      default: state_d = ENC_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ENC_IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_encoder_8to3_serial.sv
// Self-checking bench for encoder_8to3_serial: directed scenarios plus randomized
// vectors compared against a bit-list reference model.
module tb_encoder_8to3_serial;
  import encoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_q[$];

  encoder_8to3_serial_if bus ();

  encoder_8to3_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: list of set-bit positions in ascending order.
  function automatic void build_model(input logic [7:0] v);
    exp_q.delete();
    for (int i = 0; i < 8; i++) if (v[i]) exp_q.push_back(i);
  endfunction

  function automatic bit zero_en();
`ifdef ENCODER_ZERO_FLAG_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic accept(input logic [7:0] v, input string tag);
    bus.in_valid = 1'b1;
    bus.in_req   = v;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL %s in_ready before accept: got %b want 1", tag, bus.in_ready);
    else n_pass++;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_req = 8'h00; bus.out_ready = 1'b0;
    step(); step();
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_idx, bus.out_last, bus.out_zero} !== 7'b0)
      $display("FAIL reset_outputs: rdy=%b vld=%b idx=%0d last=%b zero=%b want all 0",
               bus.in_ready, bus.out_valid, bus.out_idx, bus.out_last, bus.out_zero);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_pattern();
    int exp_idx[3] = '{2, 5, 7};
    bus.out_ready = 1'b1;
    accept(8'b1010_0100, "pattern");
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== idx_t'(exp_idx[k]) || bus.out_last !== (k == 2) || bus.out_zero !== 1'b0)
        $display("FAIL pattern_beat%0d: vld=%b idx=%0d last=%b zero=%b want 1/%0d/%b/0",
                 k, bus.out_valid, bus.out_idx, bus.out_last, bus.out_zero, exp_idx[k], (k == 2));
      else n_pass++;
      step();
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL pattern_done: vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_stall();
    bus.out_ready = 1'b0;
    accept(8'hFF, "stall");
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd0 || bus.out_last !== 1'b0)
        $display("FAIL stall_hold%0d: vld=%b idx=%0d last=%b want 1/0/0", c, bus.out_valid, bus.out_idx, bus.out_last);
      else n_pass++;
      step();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== idx_t'(k) || bus.out_last !== (k == 7))
        $display("FAIL stall_beat%0d: vld=%b idx=%0d last=%b want 1/%0d/%b",
                 k, bus.out_valid, bus.out_idx, bus.out_last, k, (k == 7));
      else n_pass++;
      step();
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) $display("FAIL stall_done_ready: got %b want 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_sample_once();
    bus.out_ready = 1'b0;
    accept(8'h80, "sample");
    bus.in_req = 8'h3C;
    step();
    bus.out_ready = 1'b1;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd7 || bus.out_last !== 1'b1)
      $display("FAIL sample_beat: vld=%b idx=%0d last=%b want 1/7/1", bus.out_valid, bus.out_idx, bus.out_last);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL sample_single: vld=%b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_zero();
    bus.out_ready = 1'b1;
    accept(8'h00, "zero");
    n_checks++;
    if (zero_en()) begin
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd0 || bus.out_zero !== 1'b1 || bus.out_last !== 1'b1)
        $display("FAIL zero_beat: vld=%b idx=%0d zero=%b last=%b want 1/0/1/1",
                 bus.out_valid, bus.out_idx, bus.out_zero, bus.out_last);
      else n_pass++;
      step();
    end else begin
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
        $display("FAIL zero_nobeat: vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
      else n_pass++;
    end
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_zero !== 1'b0)
      $display("FAIL zero_after: vld=%b rdy=%b zero=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.out_zero);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    accept(8'h0F, "rstmid");
    step(); step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd2)
      $display("FAIL rstmid_before: vld=%b idx=%0d want 1/2", bus.out_valid, bus.out_idx);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) $display("FAIL rstmid_ready: got %b want 0", bus.in_ready);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_idx !== 3'd0 || bus.out_last !== 1'b0)
      $display("FAIL rstmid_outputs: vld=%b idx=%0d last=%b want 0/0/0", bus.out_valid, bus.out_idx, bus.out_last);
    else n_pass++;
    rst = 1'b0;
    #1;
    accept(8'h02, "rstmid_next");
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd1 || bus.out_last !== 1'b1)
      $display("FAIL rstmid_next: vld=%b idx=%0d last=%b want 1/1/1", bus.out_valid, bus.out_idx, bus.out_last);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL rstmid_next_done: vld=%b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_req    = 8'h01;
    step();
    bus.in_req = 8'h40;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd0 || bus.out_last !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL b2b_first: vld=%b idx=%0d last=%b rdy=%b want 1/0/1/0",
               bus.out_valid, bus.out_idx, bus.out_last, bus.in_ready);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL b2b_gap: vld=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
    else n_pass++;
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd6 || bus.out_last !== 1'b1)
      $display("FAIL b2b_second: vld=%b idx=%0d last=%b want 1/6/1", bus.out_valid, bus.out_idx, bus.out_last);
    else n_pass++;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL b2b_done: vld=%b want 0", bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [7:0] v;
      bit         zflag;
      int         budget;
      v = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      build_model(v);
      zflag = (v == 8'h00) && zero_en();
      if (zflag) exp_q.push_back(0);
      bus.out_ready = 1'b0;
      accept(v, "rand");
      budget = 0;
      while (exp_q.size() > 0 && budget < 100) begin
        bus.in_req    = 8'($urandom);
        bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== idx_t'(exp_q[0]) ||
            bus.out_last !== (exp_q.size() == 1) || bus.out_zero !== zflag)
          $display("FAIL rand_beat v=%h: vld=%b idx=%0d last=%b zero=%b want 1/%0d/%b/%b",
                   v, bus.out_valid, bus.out_idx, bus.out_last, bus.out_zero,
                   exp_q[0], (exp_q.size() == 1), zflag);
        else n_pass++;
        if (bus.out_ready) void'(exp_q.pop_front());
        step();
        budget++;
      end
      n_checks++;
      if (exp_q.size() != 0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
        $display("FAIL rand_end v=%h: left=%0d vld=%b rdy=%b want 0/0/1",
                 v, exp_q.size(), bus.out_valid, bus.in_ready);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_stall();
    test_sample_once();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
